// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg: shared decode constants for the dispatch path.
// Contents: RV32I major-opcode constants, the dispatch class enum and a
// classify() helper mapping an opcode to the unit that must accept it.
// Also imported by the ROB and RS decode.
package dispatch_queue_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        CLASS_ALU      = 2'd0,
        CLASS_LSU      = 2'd1,
        CLASS_ROB_ONLY = 2'd2,
        CLASS_ILLEGAL  = 2'd3
    } class_e;

    // LUI only needs a ROB slot; illegal encodings go to the ROB so the
    // exception is raised in order at commit.
    function automatic class_e classify(logic [6:0] opcode);
        class_e c;
        case (opcode)
            OPC_LOAD, OPC_STORE:                  c = CLASS_LSU;
            OPC_LUI:                              c = CLASS_ROB_ONLY;
            OPC_OP, OPC_OP_IMM, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_AUIPC:         c = CLASS_ALU;
            default:                              c = CLASS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: fetch-side push, dispatch-side head and status bundle.
// master: fetcher/dispatch environment (drives push, control and full flags).
// slave:  dispatch_queue (drives head, fire, count, fetch_need, err_overflow).
interface dispatch_queue_if #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH) + 2;

    logic              rdy_in;
    logic              clear_in;
    logic              push_valid;
    logic [INST_W-1:0] push_inst;
    logic [PC_W-1:0]   push_pc;
    logic              fetch_need;
    logic              rob_full;
    logic              rs_full;
    logic              lsb_full;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic [1:0]        out_class;
    logic              out_fire;
    logic [CNT_W-1:0]  count;
    logic              err_overflow;

    modport master (
        output rdy_in, clear_in, push_valid, push_inst, push_pc,
        output rob_full, rs_full, lsb_full,
        input  fetch_need, out_valid, out_inst, out_pc, out_class, out_fire,
        input  count, err_overflow
    );

    modport slave (
        input  rdy_in, clear_in, push_valid, push_inst, push_pc,
        input  rob_full, rs_full, lsb_full,
        output fetch_need, out_valid, out_inst, out_pc, out_class, out_fire,
        output count, err_overflow
    );

endinterface

// File: rtl/dispatch_queue_ring_buffer.sv
// dispatch_queue_ring_buffer: DEPTH-entry FIFO storage with wrap-around
// pointers and an occupancy counter.
// Ports: clk_i, rst_i (sync, active-high), clear_i (flush), push_i/
// push_data_i (write at tail), pop_i (advance head), pop_data_o (head
// entry, valid when !empty_o), empty_o, full_o, count_o.
// The caller never pushes when full without popping, nor pops when empty.
module dispatch_queue_ring_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy tracks which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: instruction buffer between fetch and ROB/RS/LSB dispatch.
// A ring buffer feeds a registered head stage; the head is classified by
// target unit and fires only when the units it needs have room.
// Ports: clk_in, rst_in (sync, active-high), bus (dispatch_queue_if.slave:
// rdy_in pause, clear_in flush, push_*, *_full in; out_*, out_fire, count,
// fetch_need, err_overflow out).
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned AFULL_SLACK = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    dispatch_queue_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 2;
    localparam int unsigned ENTRY_W = INST_W + PC_W;

    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] out_inst_q,  out_inst_d;
    logic [PC_W-1:0]   out_pc_q,    out_pc_d;
    class_e            out_class_q, out_class_d;
    logic              err_q,       err_d;

    logic               active;
    logic               unit_free;
    logic               fire;
    logic               head_free;
    logic               buf_pop;
    logic               buf_push;
    logic               bypass;
    logic               push_req;
    logic               overflow;
    logic               buf_empty;
    logic               buf_full;
    logic [PTR_W:0]     buf_count;
    logic [ENTRY_W-1:0] buf_rdata;
    logic [INST_W-1:0]  buf_inst;
    logic [PC_W-1:0]    buf_pc;
    logic [CNT_W-1:0]   count_total;
    logic [31:0]        need_sum;

    assign active = bus.rdy_in & ~bus.clear_in;

    always_comb begin
        unit_free = 1'b1;
        unique case (out_class_q)
            CLASS_ALU:      unit_free = ~bus.rs_full;
            CLASS_LSU:      unit_free = ~bus.lsb_full;
            CLASS_ROB_ONLY: unit_free = 1'b1;
            CLASS_ILLEGAL:  unit_free = 1'b1;
        endcase
    end

    assign fire      = out_valid_q & active & ~bus.rob_full & unit_free;
    assign head_free = ~out_valid_q | fire;

    // Buffer contents are always older than the incoming push, so the head
    // takes from the buffer first and only bypasses when it is empty.
    assign buf_pop  = active & head_free & ~buf_empty;
    assign bypass   = active & head_free & buf_empty & bus.push_valid;
    assign push_req = active & bus.push_valid & ~bypass;
    assign overflow = push_req & buf_full & ~buf_pop;
    assign buf_push = push_req & ~overflow;

    dispatch_queue_ring_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ring_buffer (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .clear_i     (bus.rdy_in & bus.clear_in),
        .push_i      (buf_push),
        .push_data_i ({bus.push_inst, bus.push_pc}),
        .pop_i       (buf_pop),
        .pop_data_o  (buf_rdata),
        .empty_o     (buf_empty),
        .full_o      (buf_full),
        .count_o     (buf_count)
    );

    assign {buf_inst, buf_pc} = buf_rdata;

    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_class_d = out_class_q;
        err_d       = err_q;
        if (bus.rdy_in) begin
            if (bus.clear_in) begin
                out_valid_d = 1'b0;
                err_d       = 1'b0;
            end else begin
                if (head_free) begin
                    if (!buf_empty) begin
                        out_valid_d = 1'b1;
                        out_inst_d  = buf_inst;
                        out_pc_d    = buf_pc;
                        out_class_d = classify(buf_inst[6:0]);
                    end else if (bus.push_valid) begin
                        out_valid_d = 1'b1;
                        out_inst_d  = bus.push_inst;
                        out_pc_d    = bus.push_pc;
                        out_class_d = classify(bus.push_inst[6:0]);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                if (overflow) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_class_q <= CLASS_ALU;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_class_q <= out_class_d;
            err_q       <= err_d;
        end
    end

    assign count_total = CNT_W'(buf_count) + CNT_W'(out_valid_q);
    assign need_sum    = 32'(count_total) + AFULL_SLACK;

    assign bus.fetch_need   = (need_sum <= DEPTH);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_inst     = out_inst_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_class    = out_class_q;
    assign bus.out_fire     = fire;
    assign bus.count        = count_total;
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: self-checking bench for dispatch_queue (DEPTH=4).
// A reference model holds every accepted instruction in one queue of
// capacity DEPTH+1; dispatches are checked in order by a monitor against a
// scoreboard queue of accepted instructions.
module tb_dispatch_queue;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned AFULL_SLACK = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dispatch_queue_if #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) bus ();

    dispatch_queue #(
        .DEPTH       (DEPTH),
        .INST_W      (32),
        .PC_W        (32),
        .AFULL_SLACK (AFULL_SLACK)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    item_t model_q[$];
    item_t sb_q[$];
    bit    model_err = 1'b0;
    bit    checking  = 1'b0;
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    n_fired   = 0;

    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_LUI  = 32'h000012B7;

    function automatic int ref_class(logic [31:0] inst);
        logic [6:0] opc;
        opc = inst[6:0];
        case (opc)
            7'b0000011, 7'b0100011: return 1;
            7'b0110111:             return 2;
            7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0010111: return 0;
            default:                return 3;
        endcase
    endfunction

    function automatic bit model_fire();
        int c;
        if (model_q.size() == 0) return 1'b0;
        if (!bus.rdy_in || bus.clear_in || bus.rob_full) return 1'b0;
        c = ref_class(model_q[0].inst);
        if (c == 0) return !bus.rs_full;
        if (c == 1) return !bus.lsb_full;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue, capacity DEPTH+1, updated on each edge.
    always @(posedge clk) begin : model_upd
        bit    f;
        item_t it;
        if (rst) begin
            model_q.delete();
            sb_q.delete();
            model_err = 1'b0;
        end else if (bus.rdy_in) begin
            if (bus.clear_in) begin
                model_q.delete();
                sb_q.delete();
                model_err = 1'b0;
            end else begin
                f = model_fire();
                if (f) void'(model_q.pop_front());
                if (bus.push_valid) begin
                    it.inst = bus.push_inst;
                    it.pc   = bus.push_pc;
                    if (model_q.size() < DEPTH + 1) begin
                        model_q.push_back(it);
                        sb_q.push_back(it);
                    end else begin
                        model_err = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on fire.
    always @(negedge clk) begin : monitor
        item_t it;
        if (checking) begin
            check("out_valid", bus.out_valid, model_q.size() != 0);
            if (model_q.size() != 0) begin
                check("head_inst", bus.out_inst, model_q[0].inst);
                check("head_pc", bus.out_pc, model_q[0].pc);
                check("head_class", bus.out_class, ref_class(model_q[0].inst));
            end
            check("out_fire", bus.out_fire, model_fire());
            check("count", bus.count, model_q.size());
            check("fetch_need", bus.fetch_need, (model_q.size() + AFULL_SLACK) <= DEPTH);
            check("err_overflow", bus.err_overflow, model_err);
            if (bus.out_fire) begin
                if (sb_q.size() == 0) begin
                    check("dispatch_unexpected", 1, 0);
                end else begin
                    it = sb_q.pop_front();
                    check("dispatch_inst", bus.out_inst, it.inst);
                    check("dispatch_pc", bus.out_pc, it.pc);
                    check("dispatch_class", bus.out_class, ref_class(it.inst));
                    n_fired++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        bus.push_valid = 1'b1;
        bus.push_inst  = inst;
        bus.push_pc    = pc;
        cyc();
        bus.push_valid = 1'b0;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin : stim
        logic [6:0]  opc_tab [10];
        logic [31:0] r;
        int          idx;
        int          budget;
        int          fired0;

        opc_tab = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111,
                    7'b1100111, 7'b1100011, 7'b0110011, 7'b0010011, 7'b1111111};

        rst            = 1'b1;
        bus.rdy_in     = 1'b1;
        bus.clear_in   = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_inst  = '0;
        bus.push_pc    = '0;
        bus.rob_full   = 1'b0;
        bus.rs_full    = 1'b0;
        bus.lsb_full   = 1'b0;
        cyc();
        cyc();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_fire", bus.out_fire, 0);
        check("reset_out_inst", bus.out_inst, 0);
        check("reset_out_pc", bus.out_pc, 0);
        check("reset_out_class", bus.out_class, 0);
        check("reset_count", bus.count, 0);
        check("reset_fetch_need", bus.fetch_need, 1);
        check("reset_err", bus.err_overflow, 0);
        rst      = 1'b0;
        checking = 1'b1;

        // Bypass: ADD on an empty queue fires one cycle after the push.
        push(I_ADD, 32'h0);
        check("bypass_valid", bus.out_valid, 1);
        check("bypass_fire", bus.out_fire, 1);
        cyc();
        check("bypass_count_after", bus.count, 0);
        repeat (2) cyc();

        // A full LSB holds a load but nothing behind it is lost.
        bus.lsb_full = 1'b1;
        push(I_LW, 32'h4);
        push(I_ADD, 32'h8);
        repeat (3) cyc();
        check("lsb_hold_pc", bus.out_pc, 32'h4);
        bus.lsb_full = 1'b0;
        repeat (3) cyc();

        // rs_full blocks ALU; rob_full blocks a ROB-only LUI.
        bus.rs_full = 1'b1;
        push(I_ADDI, 32'hC);
        repeat (2) cyc();
        bus.rs_full = 1'b0;
        repeat (2) cyc();
        bus.rob_full = 1'b1;
        push(I_LUI, 32'h10);
        repeat (2) cyc();
        check("lui_blocked", bus.out_fire, 0);
        bus.rob_full = 1'b0;
        check("lui_class", bus.out_class, 2);
        repeat (2) cyc();

        // Overflow: no dispatch, six pushes into capacity five.
        bus.rob_full = 1'b1;
        for (int i = 0; i < 6; i++) push(I_ADD, 32'h100 + 32'(i * 4));
        check("ovf_count", bus.count, 5);
        check("ovf_err", bus.err_overflow, 1);
        check("ovf_fetch_need", bus.fetch_need, 0);
        bus.clear_in = 1'b1;
        push(I_ADD, 32'h200);
        bus.clear_in = 1'b0;
        check("clear_count", bus.count, 0);
        check("clear_valid", bus.out_valid, 0);
        check("clear_err", bus.err_overflow, 0);
        bus.rob_full = 1'b0;
        repeat (3) cyc();

        // Flush of a partly filled queue with a simultaneous push.
        bus.rob_full = 1'b1;
        for (int i = 0; i < 3; i++) push(I_LW, 32'h300 + 32'(i * 4));
        bus.clear_in = 1'b1;
        push(I_ADDI, 32'h400);
        bus.clear_in = 1'b0;
        bus.rob_full = 1'b0;
        repeat (3) cyc();
        check("flush_idle_count", bus.count, 0);

        // Random run: 20 instructions, random back-pressure, one pause.
        idx    = 0;
        budget = 0;
        fired0 = n_fired;
        while ((idx < 20 || model_q.size() != 0) && budget < 2000) begin
            bus.rob_full = ($urandom_range(0, 3) == 0);
            bus.rs_full  = ($urandom_range(0, 2) == 0);
            bus.lsb_full = ($urandom_range(0, 2) == 0);
            bus.rdy_in   = !(budget >= 10 && budget < 13);
            if (idx < 20 && model_q.size() < DEPTH + 1 && $urandom_range(0, 3) != 0) begin
                r              = $urandom();
                bus.push_valid = 1'b1;
                bus.push_inst  = {r[31:7], opc_tab[$urandom_range(0, 9)]};
                bus.push_pc    = 32'(idx * 4);
                if (bus.rdy_in) idx++;
            end else begin
                bus.push_valid = 1'b0;
            end
            cyc();
            budget++;
        end
        bus.push_valid = 1'b0;
        bus.rdy_in     = 1'b1;
        bus.rob_full   = 1'b0;
        bus.rs_full    = 1'b0;
        bus.lsb_full   = 1'b0;
        check("rand_drained_in_budget", budget < 2000, 1);
        check("rand_dispatch_total", n_fired - fired0, 20);
        repeat (2) cyc();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised instruction buffer between the instruction fetcher and the ROB/RS/LSB dispatch logic. Holds fetched instructions and PCs in a ring buffer feeding a registered head stage, then classifies the head by target unit. The head dispatches only when the units it actually needs have space, so a full LSB no longer stalls ALU instructions. Supports a one-cycle flush, an empty-queue bypass and a fetch throttle threshold.

## Interface
- DEPTH, 32, ring-buffer entries; power of two, ≥4
- INST_W, 32, instruction width
- PC_W, 32, PC width
- AFULL_SLACK, 2, entries kept free for in-flight fetches
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  low = pause: all state holds, push ignored, no fire
- clear_in  in  1  flush (mispredict/jalr redirect)
- push_valid  in  1  fetcher presents an instruction
- push_inst  in  INST_W  instruction word
- push_pc  in  PC_W  instruction address
- fetch_need  out  1  fetcher may issue requests
- rob_full, rs_full, lsb_full  in  1 each  downstream occupancy
- out_valid  out  1  head register holds an instruction
- out_inst  out  INST_W  head instruction
- out_pc  out  PC_W  head PC
- out_class  out  2  0 ALU, 1 LSU, 2 ROB_ONLY, 3 ILLEGAL
- out_fire  out  1  head dispatched this cycle; downstream latches out_* on it
- count  out  $clog2(DEPTH)+2  buffer entries + head valid
- err_overflow  out  1  sticky: push while buffer full

## Operation
- Storage: DEPTH-entry ring buffer, pointers $clog2(DEPTH) bits, wrap modulo DEPTH; head register adds one entry (total capacity DEPTH+1).
- Class, from opcode inst[6:0]: 0000011/0100011 → LSU; 0110111 (LUI) → ROB_ONLY; 0110011, 0010011, 1100011, 1101111, 1100111, 0010111 → ALU; any other → ILLEGAL.
- fire = out_valid & rdy_in & !clear_in & !rob_full & (ALU: !rs_full; LSU: !lsb_full; ROB_ONLY/ILLEGAL: 1). out_fire = fire, combinational.
- Head refill (edge, when head empty or firing): from ring buffer if non-empty; else from push if push_valid (bypass); else out_valid←0.
- Push with ring buffer non-empty, or head occupied and not firing: written at tail.
- Push with buffer full and not simultaneously drained: dropped, err_overflow←1.
- Simultaneous push and refill-from-buffer: both happen; buffer occupancy unchanged.
- fetch_need = (count + AFULL_SLACK ≤ DEPTH).
- clear_in (rdy_in high): next edge empties buffer and head, count←0, push that cycle discarded, err_overflow←0.
- Priority: rst_in > !rdy_in > clear_in > normal.
- Reset values: out_valid 0, out_fire 0, count 0, fetch_need 1, err_overflow 0, pointers 0; out_inst/out_pc/out_class 0.

## Timing
- Push → out_valid: 1 cycle when buffer empty and head free/firing (bypass); otherwise entry waits behind older entries, one dispatch per cycle max.
- Sustained throughput 1 instr/cycle with no downstream stall.
- out_* stable while out_valid & !out_fire.
- count, fetch_need, err_overflow registered-derived; update the edge after the event.
- Pause (rdy_in low) mid-stream: nothing moves; resumes identically on the next rdy_in cycle.
- Reset mid-operation: all contents discarded at that edge.

## Structure
- Shared package: opcode constants (LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH, OP, OP_IMM) and class enum (CLASS_ALU/LSU/ROB_ONLY/ILLEGAL); reused by ROB and RS decode.
- One sub-module: ring_buffer (parametrised storage + pointers + occupancy, push/pop/clear); head register, classify and fire logic in dispatch_queue.

## Test plan
- Reset, push ADD (0x00B50533, pc 0x0) on empty queue → out_valid next cycle, out_class 0, out_fire same cycle with all fulls low, count back to 0.
- lsb_full=1, queue holds LW, ADD → LW held, no fire, out_pc stable; drop lsb_full → LW fires, ADD fires next cycle.
- Head ADDI with rs_full=1 → no fire; raise rob_full alone with LUI head → LUI blocked; rob_full low → LUI fires class 2.
- DEPTH=4, AFULL_SLACK=2, no dispatch, push 6 → fetch_need low when count reaches 3, 6th push sets err_overflow, count 5.
- Fill 3 entries, assert clear_in with push_valid → next cycle out_valid 0, count 0, pushed instruction absent.
- DEPTH=4, push/fire 20 instrs with pcs 0,4,…,76 under random full toggles → dispatch order equals push order across pointer wraps; rdy_in low 3 cycles mid-run freezes all outputs.
